// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic output path.
// Optional accumulate mode is selected by the COLLECTOR_ACCUM_EN macro.
package systolic_pkg;

  typedef enum logic [1:0] {C_IDLE, C_COLLECT, C_DONE} collector_state_e;

  localparam int unsigned WORD_SIZE_DEF = 16;
  localparam int unsigned ROWS_DEF      = 4;

  typedef logic [WORD_SIZE_DEF-1:0] word_t;

  // Row counters must reach ROWS itself, hence the extra bit.
  localparam int unsigned ROW_IDX_W = $clog2(ROWS_DEF) + 1;

  function automatic int unsigned row_idx_w(input int unsigned rows);
    return $clog2(rows) + 1;
  endfunction

endpackage

// File: rtl/collector_col_capture.sv
// Per-column capture control: phase counter over the hold window, capture
// counter (next write row) and overflow detection.
module collector_col_capture
  import systolic_pkg::*;
#(
  parameter int unsigned ROWS        = 4,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        en_i,
  input  logic                        valid_i,
  output logic                        cap_o,
  output logic                        ovf_o,
  output logic [row_idx_w(ROWS)-1:0]  wr_row_o
);

  localparam int unsigned IDX_W = row_idx_w(ROWS);
  localparam int unsigned PH_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [PH_W-1:0]  ph_q, ph_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_comb begin
    ph_d  = ph_q;
    cnt_d = cnt_q;
    cap_o = 1'b0;
    ovf_o = 1'b0;
    if (clr_i) begin
      ph_d  = '0;
      cnt_d = '0;
    end else if (!valid_i) begin
      ph_d = '0;
    end else if (en_i) begin
      ph_d = (ph_q == PH_W'(HOLD_CYCLES - 1)) ? '0 : ph_q + 1'b1;
      // Only the first clock of each held word is a capture.
      if (ph_q == '0) begin
        if (cnt_q == IDX_W'(ROWS)) begin
          ovf_o = 1'b1;
        end else begin
          cap_o = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ph_q  <= '0;
      cnt_q <= '0;
    end else begin
      ph_q  <= ph_d;
      cnt_q <= cnt_d;
    end
  end

  assign wr_row_o = cnt_q;

endmodule

// File: rtl/systolic_output_collector.sv
// De-skews staggered systolic column outputs into a ROWS x COLS buffer and
// streams completed rows in order. Accumulate mode: COLLECTOR_ACCUM_EN.
module systolic_output_collector
  import systolic_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned ROWS        = 4,
  parameter int unsigned COLS        = 4,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         arm,
  input  logic [COLS*WORD_SIZE-1:0]    bottom_out,
  input  logic [COLS-1:0]              output_col_valid,
  output logic [COLS*WORD_SIZE-1:0]    out_row_data,
  output logic [row_idx_w(ROWS)-1:0]   out_row_idx,
  output logic                         out_row_valid,
  input  logic                         out_row_ready,
  output logic                         out_last,
  output logic                         done,
  output logic                         err_overflow
`ifdef COLLECTOR_ACCUM_EN
  ,
  input  logic                         accum
`endif
);

  localparam int unsigned IDX_W = row_idx_w(ROWS);
  localparam int unsigned RA_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  collector_state_e state_q, state_d;

  logic [WORD_SIZE-1:0]     buf_q [ROWS][COLS];
  logic [WORD_SIZE-1:0]     wr_word [COLS];
  logic [IDX_W-1:0]         cnt [COLS];
  logic [COLS-1:0]          cap, ovf;
  logic [IDX_W-1:0]         rd_row_q, rd_row_d, nxt_row;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [COLS*WORD_SIZE-1:0] data_q, data_d;
  logic                     valid_q, valid_d, last_q, last_d;
  logic                     done_q, done_d, err_q, err_d;
  logic                     hs, row_ok, accum_q;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    collector_col_capture #(
      .ROWS        (ROWS),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_cap (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .clr_i    (arm),
      .en_i     (state_q == C_COLLECT),
      .valid_i  (output_col_valid[c]),
      .cap_o    (cap[c]),
      .ovf_o    (ovf[c]),
      .wr_row_o (cnt[c])
    );
  end

`ifdef COLLECTOR_ACCUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   accum_q <= 1'b0;
    else if (arm) accum_q <= accum;
  end
`else
  assign accum_q = 1'b0;
`endif

  always_comb begin
    for (int unsigned c = 0; c < COLS; c++) begin
      wr_word[c] = bottom_out[c*WORD_SIZE +: WORD_SIZE]
                 + (accum_q ? buf_q[cnt[c][RA_W-1:0]][c] : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++)
          buf_q[r][c] <= '0;
    end else begin
      for (int unsigned c = 0; c < COLS; c++)
        if (cap[c]) buf_q[cnt[c][RA_W-1:0]][c] <= wr_word[c];
    end
  end

  // Look one row ahead on a handshake so rows can leave at one per clock.
  always_comb begin
    hs      = valid_q && out_row_ready;
    nxt_row = rd_row_q + IDX_W'(hs);
    row_ok  = 1'b1;
    data_d  = data_q;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (cnt[c] <= nxt_row) row_ok = 1'b0;
      data_d[c*WORD_SIZE +: WORD_SIZE] = buf_q[nxt_row[RA_W-1:0]][c];
    end
    if (!row_ok) data_d = data_q;

    state_d  = state_q;
    rd_row_d = rd_row_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    last_d   = last_q;
    done_d   = 1'b0;
    err_d    = err_q | (|ovf);

    if (arm) begin
      state_d  = C_COLLECT;
      rd_row_d = '0;
      valid_d  = 1'b0;
      last_d   = 1'b0;
      err_d    = 1'b0;
      data_d   = data_q;
    end else begin
      case (state_q)
        C_COLLECT: begin
          if (hs) rd_row_d = nxt_row;
          if (hs && last_q) begin
            state_d = C_DONE;
            done_d  = 1'b1;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = data_q;
          end else if (!valid_q || hs) begin
            valid_d = row_ok;
            last_d  = row_ok && (nxt_row == IDX_W'(ROWS - 1));
            if (row_ok) idx_d = nxt_row;
          end else begin
            data_d = data_q;
          end
        end
        C_DONE:  state_d = C_IDLE;
        default: data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= C_IDLE;
      rd_row_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_row_q <= rd_row_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign out_row_valid = valid_q;
  assign out_row_data  = data_q;
  assign out_row_idx   = idx_q;
  assign out_last      = last_q;
  assign done          = done_q;
  assign err_overflow  = err_q;

endmodule

// File: tb/tb_systolic_output_collector.sv
// Bench for systolic_output_collector: staggered column streams against a
// row/column model of the result buffer. Accumulate pass under COLLECTOR_ACCUM_EN.
module tb_systolic_output_collector;
  import systolic_pkg::*;

  localparam int W = 16;
  localparam int R = 4;
  localparam int C = 4;
  localparam int H = 2;

  logic             clk = 1'b0;
  logic             rst_n, arm, out_row_ready;
  logic [C*W-1:0]   bottom_out, out_row_data;
  logic [C-1:0]     output_col_valid;
  logic [2:0]       out_row_idx;
  logic             out_row_valid, out_last, done, err_overflow;
`ifdef COLLECTOR_ACCUM_EN
  logic             accum;
`endif

  systolic_output_collector #(
    .WORD_SIZE   (W),
    .ROWS        (R),
    .COLS        (C),
    .HOLD_CYCLES (H)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .arm              (arm),
    .bottom_out       (bottom_out),
    .output_col_valid (output_col_valid),
    .out_row_data     (out_row_data),
    .out_row_idx      (out_row_idx),
    .out_row_valid    (out_row_valid),
    .out_row_ready    (out_row_ready),
    .out_last         (out_last),
    .done             (done),
    .err_overflow     (err_overflow)
`ifdef COLLECTOR_ACCUM_EN
    ,
    .accum            (accum)
`endif
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  word_t words [C][8];
  int    st [C];
  int    nw [C];
  int    len;
  word_t model [R][C];
  bit    acc_cur;
  int    rx, cyc, ready_after;
  int    hs_cyc [R];
  bit    pend_arm, chk_zero, stall_prev, exp_done;
  logic [C*W-1:0] held_data;
  logic [2:0]     held_idx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Column c: nw[c] words, each held H clocks, starting st[c] clocks in.
  task automatic setup(input int kind, input int ovf_col, input bit acc, input word_t fill);
    len = 0;
    for (int c = 0; c < C; c++) begin
      st[c] = (kind == 0) ? 2 * c : int'($urandom_range(0, 5));
      nw[c] = (c == ovf_col) ? R + 1 : R;
      for (int k = 0; k < nw[c]; k++)
        words[c][k] = (kind == 0) ? word_t'(16 * k + c) :
                      (kind == 2) ? fill : word_t'($urandom);
      if (st[c] + nw[c] * H > len) len = st[c] + nw[c] * H;
      for (int k = 0; k < R; k++)
        model[k][c] = acc ? word_t'(model[k][c] + words[c][k]) : words[c][k];
    end
    acc_cur = acc;
  endtask

  task automatic step(input int t);
    logic [C*W-1:0] er;
    @(negedge clk);
    if (chk_zero) begin
      chk("rearm_valid", out_row_valid, 0);
      chk("rearm_err", err_overflow, 0);
      chk_zero = 0;
    end else if (stall_prev) begin
      chk("stall_valid", out_row_valid, 1);
      chk("stall_data", out_row_data, held_data);
      chk("stall_idx", out_row_idx, held_idx);
    end
    chk("done", done, exp_done);
    exp_done = 0;

    output_col_valid = '0;
    bottom_out       = '0;
    if (t >= 0)
      for (int c = 0; c < C; c++)
        if (t >= st[c] && t < st[c] + nw[c] * H) begin
          output_col_valid[c]    = 1'b1;
          bottom_out[c*W +: W]   = words[c][(t - st[c]) / H];
        end
    arm = pend_arm;
`ifdef COLLECTOR_ACCUM_EN
    accum = acc_cur;
`endif
    out_row_ready = !pend_arm && (t < 0 || t >= ready_after);

    if (out_row_valid && out_row_ready) begin
      for (int c = 0; c < C; c++) er[c*W +: W] = (rx < R) ? model[rx][c] : '1;
      chk("row_idx", out_row_idx, rx);
      chk("row_data", out_row_data, er);
      chk("row_last", out_last, (rx == R - 1));
      if (rx < R) hs_cyc[rx] = cyc;
      rx++;
      if (rx == R) exp_done = 1;
    end
    stall_prev = out_row_valid && !out_row_ready && !pend_arm;
    held_data  = out_row_data;
    held_idx   = out_row_idx;
    if (pend_arm) begin
      chk_zero = 1;
      rx       = 0;
      exp_done = 0;
      pend_arm = 0;
    end
    cyc++;
  endtask

  task automatic do_arm();
    pend_arm = 1;
    step(-1);
  endtask

  task automatic feed();
    for (int t = 0; t < len; t++) step(t);
  endtask

  task automatic drain(input int stop);
    int n = 0;
    while (rx < stop && n < 200) begin
      step(-1);
      n++;
    end
    chk("drain_rows", rx, stop);
  endtask

  initial begin
    rst_n = 0; arm = 0; out_row_ready = 0; bottom_out = '0; output_col_valid = '0;
`ifdef COLLECTOR_ACCUM_EN
    accum = 0;
`endif
    rx = 0; cyc = 0; ready_after = 0; acc_cur = 0;
    pend_arm = 0; chk_zero = 0; stall_prev = 0; exp_done = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_row_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_overflow, 0);
    chk("rst_data", out_row_data, 0);
    chk("rst_idx", out_row_idx, 0);
    rst_n = 1;

    // Staggered 4x4, consumer always ready
    setup(0, -1, 0, '0);
    ready_after = 0;
    do_arm();
    feed();
    drain(R);
    step(-1);
    chk("stag_err", err_overflow, 0);

    // Backpressure until every column has been captured
    setup(1, -1, 0, '0);
    ready_after = len;
    do_arm();
    feed();
    drain(R);
    step(-1);
    chk("b2b_span", hs_cyc[R-1] - hs_cyc[0], R - 1);

    // Column 1 gets a fifth word: dropped, sticky error
    setup(1, 1, 0, '0);
    ready_after = len;
    do_arm();
    feed();
    chk("ovf_flag", err_overflow, 1);
    drain(R);
    step(-1);
    chk("ovf_sticky", err_overflow, 1);

    // Re-arm after row 1 handshake, then a fresh stream
    setup(1, 0, 0, '0);
    ready_after = len;
    do_arm();
    feed();
    drain(2);
    pend_arm = 1;
    step(-1);
    setup(1, -1, 0, '0);
    ready_after = 0;
    feed();
    drain(R);
    step(-1);

    // Async reset while a row is offered and stalled
    setup(1, 2, 0, '0);
    ready_after = 100000;
    do_arm();
    feed();
    repeat (3) step(1000);
    chk("pre_rst_valid", out_row_valid, 1);
    chk("pre_rst_err", err_overflow, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", out_row_valid, 0);
    chk("arst_last", out_last, 0);
    chk("arst_err", err_overflow, 0);
    chk("arst_data", out_row_data, 0);
    chk("arst_idx", out_row_idx, 0);
    @(negedge clk);
    rst_n = 1;
    stall_prev = 0; rx = 0; exp_done = 0; chk_zero = 0;
    setup(1, 3, 0, '0);
    ready_after = 0;
    feed();
    repeat (2) step(-1);
    chk("idle_valid", out_row_valid, 0);
    chk("idle_err", err_overflow, 0);
    setup(1, -1, 0, '0);
    do_arm();
    feed();
    drain(R);
    step(-1);

`ifdef COLLECTOR_ACCUM_EN
    // Two passes of 1 -> 2; then 0xFFFF + 1 wraps to 0
    setup(2, -1, 0, word_t'(1));
    do_arm(); feed(); drain(R); step(-1);
    setup(2, -1, 1, word_t'(1));
    do_arm(); feed(); drain(R); step(-1);
    setup(2, -1, 0, word_t'(16'hFFFF));
    do_arm(); feed(); drain(R); step(-1);
    setup(2, -1, 1, word_t'(1));
    do_arm(); feed(); drain(R); step(-1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_output_collector.md
# systolic_output_collector

Receive side of the systolic matmul output stream. Samples the staggered per-column `bottom_out` words qualified by `output_col_valid` and de-skews them into a ROWS x COLS result buffer. Streams completed result rows out over a valid/ready handshake, in row order. Sits between the systolic array bottom edge / matmul FSM and the result consumer (writeback or BIST comparator).

## Interface
- `WORD_SIZE`, 16, bits per result element.
- `ROWS`, 4, result rows; equals array rows.
- `COLS`, 4, result columns; equals array columns.
- `HOLD_CYCLES`, 2, clocks each output word is held on `bottom_out` (one matmul cycle = 2 clk).
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `arm`  in  1  one-cycle pulse; clears counters, enters COLLECT.
- `bottom_out`  in  COLS*WORD_SIZE  column c at `[c*WORD_SIZE +: WORD_SIZE]`.
- `output_col_valid`  in  COLS  bit c qualifies column c.
- `out_row_data`  out  COLS*WORD_SIZE  result row, same column packing.
- `out_row_idx`  out  $clog2(ROWS)+1  row index of `out_row_data`.
- `out_row_valid`  out  1  row offered.
- `out_row_ready`  in  1  consumer accepts.
- `out_last`  out  1  offered row is ROWS-1.
- `done`  out  1  one-cycle pulse after the last row handshake.
- `err_overflow`  out  1  sticky; a capture occurred in a column that already held ROWS words.
- `accum`  in  1  present only with COLLECTOR_ACCUM_EN.

## Operation
- States:
  - IDLE: no capture; `arm` -> COLLECT.
  - COLLECT: capture and stream. Leave when all ROWS rows have been handshaken -> DONE.
  - DONE: pulse `done` for one cycle -> IDLE.
- Per-column capture counter `cap_cnt[c]` (0..ROWS) and phase counter `ph[c]` (0..HOLD_CYCLES-1).
  - In COLLECT, when `output_col_valid[c]` is high, `ph[c]` increments and wraps.
  - Capture happens when valid is high and `ph[c]==0`: store the word into `buf[cap_cnt[c]][c]` and increment `cap_cnt[c]`.
  - When valid is low, `ph[c]` is cleared to 0.
- A capture with `cap_cnt[c]==ROWS` is dropped and sets `err_overflow`.
- The k-th capture in column c is result row k.
- Row r is complete when `cap_cnt[c] > r` for every c.
- Read pointer `rd_row` (0..ROWS) offers row `rd_row` once that row is complete. The handshake (`out_row_valid && out_row_ready`) increments `rd_row`.
- Captures into later rows proceed in parallel with readout of earlier rows.
- `arm` in any state, including mid-COLLECT or mid-drain:
  - clears `cap_cnt`, `ph`, `rd_row` and `err_overflow`;
  - drops `out_row_valid` the next cycle;
  - enters COLLECT.
  - Buffer contents are not cleared.
- Capture while in IDLE or DONE: ignored. No error is raised.
- Arithmetic: buffer stores WORD_SIZE bits; no widening.

## Timing
- Reset values:
  - `out_row_valid`, `out_last`, `done`, `err_overflow` = 0.
  - `out_row_data` = 0, `out_row_idx` = 0.
  - state = IDLE; all counters 0.
- Capture latency: a word sampled at edge N is visible in the buffer after N. Its row may be offered with `out_row_valid` high from edge N+1, i.e. one registered stage.
- `out_row_valid`, `out_row_data`, `out_row_idx` and `out_last` are registered. While valid is high and ready is low, all of them are held stable.
- After a handshake, the next row, if complete, is offered in the following cycle. This allows back-to-back rows at 1 row per clk.
- `done` is asserted the cycle after the handshake of row ROWS-1.
- Reset is asynchronous assert and synchronous deassert; the deassert is handled at the SoC level.

## Configuration
- `COLLECTOR_ACCUM_EN` defined:
  - `accum` port exists and is sampled on `arm`.
  - If `accum` was set at `arm`, each capture writes `buf + word`, modulo 2^WORD_SIZE. This supports K-tiled matmul.
  - Otherwise each capture overwrites.
- Not defined: the port is absent and captures always overwrite.

## Structure
- Shared package `systolic_pkg`:
  - collector state enum `{C_IDLE, C_COLLECT, C_DONE}`;
  - `word_t` typedef;
  - row index width constant.
- Sub-module `collector_col_capture`, one instance per column:
  - contains the phase counter, capture counter and overflow detect;
  - outputs the capture strobe and write row.
- The top level holds the buffer, the completion compare and the output register.

## Test plan
- **Staggered 4x4:** ROWS=COLS=4, HOLD=2. Column c valid for 8 clks starting 2c clks after column 0, carrying value 16*row+c. Required: rows 0..3 come out as {16r+0..16r+3}, `out_last` on row 3, `done` one clk later.
- **Backpressure:** hold `out_row_ready` low until all columns are captured, then high continuously. Required: rows 0..3 on consecutive clks; data stable while stalled.
- **Overflow:** hold column 1 valid for 10 clks with HOLD=2. Required: 5th capture drops and `err_overflow` is 1; buffer row 3 keeps the 4th word.
- **Re-arm mid-drain:** pulse `arm` after row 1 handshake. Required: `out_row_valid` goes to 0 next clk, `err_overflow` is 0, and a fresh stream restarts at `out_row_idx`=0.
- **Async reset mid-COLLECT:** drop `rst_n` mid-COLLECT. Required: all outputs go to 0 immediately; captures are ignored until `arm`.
- **Accumulate (COLLECTOR_ACCUM_EN):** two passes of all-ones words, second pass with `accum`=1. Required: every element = 0x0002, and 0xFFFF+0x0001 wraps to 0x0000.
